// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes plus the LED GPIO register map and CTRL bit positions.
package axi_lite_pkg;

   typedef logic [1:0] resp_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_SLVERR = 2'b10;

   localparam logic [2:0] OFF_LEDG   = 3'd0;
   localparam logic [2:0] OFF_LEDR   = 3'd1;
   localparam logic [2:0] OFF_CTRL   = 3'd2;
   localparam logic [2:0] OFF_PERIOD = 3'd3;
   localparam logic [2:0] OFF_ID     = 3'd4;

   localparam int CTRL_BLINK_EN = 0;
   localparam int CTRL_INVERT   = 1;

   function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] merged;
      for (int b = 0; b < 4; b++) begin
         merged[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/led_blink_timer.sv
// Free-running blink phase generator: phase toggles every `period` cycles while enabled,
// and sits at 1 whenever blinking is disabled or the period is zero.
module led_blink_timer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [31:0] period,
   input  logic        restart,
   output logic        phase
);

   logic [31:0] cnt_q, cnt_d;
   logic        phase_q, phase_d;
   logic        active;
   logic        wrap;

   // A restart only rewinds the count; a wrap landing on the same cycle still toggles.
   always_comb begin
      active  = enable && (period != 32'd0);
      wrap    = active && (cnt_q == period - 32'd1);
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (!active) begin
         cnt_d   = 32'd0;
         phase_d = 1'b1;
      end else begin
         if (wrap) phase_d = ~phase_q;
         cnt_d = (wrap || restart) ? 32'd0 : cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= 32'd0;
         phase_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/axi_lite_led_gpio.sv
// AXI4-Lite slave holding the LED registers, blink control and ID, driving registered
// LEDG/LEDR pins through a blink/invert output stage.
module axi_lite_led_gpio
   import axi_lite_pkg::*;
#(
   parameter int          ADDR_W    = 32,
   parameter logic [31:0] BLINK_RST = 32'd25_000_000,
   parameter logic [31:0] ID_VAL    = 32'h4C45_4401
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic [ADDR_W-1:0] AWADDR,
   input  logic              AWVALID,
   output logic              AWREADY,
   input  logic [31:0]       WDATA,
   input  logic [3:0]        WSTRB,
   input  logic              WVALID,
   output logic              WREADY,
   output logic [1:0]        BRESP,
   output logic              BVALID,
   input  logic              BREADY,
   input  logic [ADDR_W-1:0] ARADDR,
   input  logic              ARVALID,
   output logic              ARREADY,
   output logic [31:0]       RDATA,
   output logic [1:0]        RRESP,
   output logic              RVALID,
   input  logic              RREADY,
   output logic [8:0]        LEDG,
   output logic [17:0]       LEDR
);

   logic        aw_pend_q, aw_pend_d;
   logic [2:0]  aw_idx_q, aw_idx_d;
   logic        w_pend_q, w_pend_d;
   logic [31:0] w_data_q, w_data_d;
   logic [3:0]  w_strb_q, w_strb_d;
   logic        awready_q, awready_d;
   logic        wready_q, wready_d;
   logic        bvalid_q, bvalid_d;
   resp_t       bresp_q, bresp_d;
   logic        arready_q, arready_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   resp_t       rresp_q, rresp_d;
   logic [8:0]  ledg_reg_q, ledg_reg_d;
   logic [17:0] ledr_reg_q, ledr_reg_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic [31:0] period_q, period_d;
   logic [8:0]  ledg_q, ledg_d;
   logic [17:0] ledr_q, ledr_d;

   logic        aw_hs, w_hs, ar_hs;
   logic [2:0]  wr_idx, rd_idx;
   logic [31:0] wr_data, wr_merged;
   logic [3:0]  wr_strb;
   logic        restart;
   logic        phase;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^{AWADDR[ADDR_W-1:5], AWADDR[1:0], ARADDR[ADDR_W-1:5], ARADDR[1:0]};

   function automatic logic [31:0] reg_value(input logic [2:0]  idx,
                                             input logic [8:0]  ledg_r,
                                             input logic [17:0] ledr_r,
                                             input logic [1:0]  ctrl_r,
                                             input logic [31:0] period_r);
      case (idx)
         OFF_LEDG:   return {23'd0, ledg_r};
         OFF_LEDR:   return {14'd0, ledr_r};
         OFF_CTRL:   return {30'd0, ctrl_r};
         OFF_PERIOD: return period_r;
         OFF_ID:     return ID_VAL;
         default:    return 32'd0;
      endcase
   endfunction

   // Write path: either half may arrive first; the commit uses whichever halves are latched
   // and whichever are handshaking this cycle, so a same-cycle AW+W commits immediately.
   always_comb begin
      aw_hs      = AWVALID && awready_q;
      w_hs       = WVALID && wready_q;
      wr_idx     = aw_pend_q ? aw_idx_q : AWADDR[4:2];
      wr_data    = w_pend_q ? w_data_q : WDATA;
      wr_strb    = w_pend_q ? w_strb_q : WSTRB;
      wr_merged  = merge_strb(reg_value(wr_idx, ledg_reg_q, ledr_reg_q, ctrl_q, period_q),
                              wr_data, wr_strb);
      aw_pend_d  = aw_pend_q;
      aw_idx_d   = aw_idx_q;
      w_pend_d   = w_pend_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      ledg_reg_d = ledg_reg_q;
      ledr_reg_d = ledr_reg_q;
      ctrl_d     = ctrl_q;
      period_d   = period_q;
      restart    = 1'b0;

      if (bvalid_q && BREADY) bvalid_d = 1'b0;

      if ((aw_pend_q || aw_hs) && (w_pend_q || w_hs)) begin
         aw_pend_d = 1'b0;
         w_pend_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = RESP_OKAY;
         case (wr_idx)
            OFF_LEDG:   ledg_reg_d = wr_merged[8:0];
            OFF_LEDR:   ledr_reg_d = wr_merged[17:0];
            OFF_CTRL: begin
               ctrl_d  = wr_merged[1:0];
               restart = 1'b1;
            end
            OFF_PERIOD: begin
               period_d = wr_merged;
               restart  = 1'b1;
            end
            default:    bresp_d = RESP_SLVERR;
         endcase
      end else begin
         if (aw_hs) begin
            aw_pend_d = 1'b1;
            aw_idx_d  = AWADDR[4:2];
         end
         if (w_hs) begin
            w_pend_d = 1'b1;
            w_data_d = WDATA;
            w_strb_d = WSTRB;
         end
      end

      awready_d = !aw_pend_d && !bvalid_d;
      wready_d  = !w_pend_d && !bvalid_d;
   end

   // Read path samples the pre-write register values, so a same-cycle write is not visible.
   always_comb begin
      ar_hs    = ARVALID && arready_q;
      rd_idx   = ARADDR[4:2];
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = reg_value(rd_idx, ledg_reg_q, ledr_reg_q, ctrl_q, period_q);
         rresp_d  = (rd_idx <= OFF_ID) ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && RREADY) begin
         rvalid_d = 1'b0;
      end
      arready_d = !rvalid_d;
   end

   always_comb begin
      ledg_d = (ledg_reg_q & {9{phase}}) ^ {9{ctrl_q[CTRL_INVERT]}};
      ledr_d = (ledr_reg_q & {18{phase}}) ^ {18{ctrl_q[CTRL_INVERT]}};
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         aw_pend_q  <= 1'b0;
         aw_idx_q   <= 3'd0;
         w_pend_q   <= 1'b0;
         w_data_q   <= 32'd0;
         w_strb_q   <= 4'd0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= 32'd0;
         rresp_q    <= RESP_OKAY;
         ledg_reg_q <= 9'd0;
         ledr_reg_q <= 18'd0;
         ctrl_q     <= 2'd0;
         period_q   <= BLINK_RST;
         ledg_q     <= 9'd0;
         ledr_q     <= 18'd0;
      end else begin
         aw_pend_q  <= aw_pend_d;
         aw_idx_q   <= aw_idx_d;
         w_pend_q   <= w_pend_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         ledg_reg_q <= ledg_reg_d;
         ledr_reg_q <= ledr_reg_d;
         ctrl_q     <= ctrl_d;
         period_q   <= period_d;
         ledg_q     <= ledg_d;
         ledr_q     <= ledr_d;
      end
   end

   led_blink_timer u_blink (
      .clk     (ACLK),
      .rst_n   (ARESETN),
      .enable  (ctrl_q[CTRL_BLINK_EN]),
      .period  (period_q),
      .restart (restart),
      .phase   (phase)
   );

   assign AWREADY = awready_q;
   assign WREADY  = wready_q;
   assign BVALID  = bvalid_q;
   assign BRESP   = bresp_q;
   assign ARREADY = arready_q;
   assign RVALID  = rvalid_q;
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;
   assign LEDG    = ledg_q;
   assign LEDR    = ledr_q;

endmodule

// File: doc/axi_lite_led_gpio.md
Name: axi_lite_led_gpio

Overview:
- AXI4-Lite slave peripheral that decodes core bus writes/reads into LED output registers and drives the board LEDG/LEDR pins.
- Sits directly downstream of the rv32im core's data-bus master inside TOP; its LEDG/LEDR outputs are TOP's LEDG/LEDR.
- Adds a free-running blink/invert stage so firmware can exercise LEDs without polling.

Parameters:
- ADDR_W, 32, AXI address width; only ADDR[4:2] is decoded, ADDR[1:0] ignored.
- BLINK_RST, 32'd25_000_000, reset value of BLINK_PERIOD register.
- ID_VAL, 32'h4C45_4401, constant returned by ID register.

Ports:
- ACLK  in  1  system clock, all logic rising-edge.
- ARESETN  in  1  asynchronous active-low reset.
- AWADDR in ADDR_W; AWVALID in 1; AWREADY out 1  write-address channel.
- WDATA in 32; WSTRB in 4; WVALID in 1; WREADY out 1  write-data channel.
- BRESP out 2; BVALID out 1; BREADY in 1  write-response channel.
- ARADDR in ADDR_W; ARVALID in 1; ARREADY out 1  read-address channel.
- RDATA out 32; RRESP out 2; RVALID out 1; RREADY in 1  read-data channel.
- LEDG  out  9  green LEDs, registered.
- LEDR  out  18  red LEDs, registered.

Behaviour:
- Register map (word offsets): 0x00 LEDG_REG[8:0] RW; 0x04 LEDR_REG[17:0] RW; 0x08 CTRL RW (bit0 BLINK_EN, bit1 INVERT); 0x0C BLINK_PERIOD[31:0] RW; 0x10 ID RO; 0x14-0x1C unmapped. Unused bits read 0.
- Reset (ARESETN low, async): all ready/valid outputs 0, BRESP/RRESP/RDATA 0, LEDG/LEDR 0, LEDG_REG/LEDR_REG/CTRL 0, BLINK_PERIOD=BLINK_RST, blink counter 0, phase 1. After release, AWREADY/WREADY/ARREADY rise on first clock edge.
- Write path: AW and W accepted independently, either order or same cycle. AWREADY=1 iff no address latched and BVALID=0; WREADY=1 iff no data latched and BVALID=0.
- Once both latched (or both handshake same cycle), write commits on next edge using WSTRB byte enables; BVALID asserts that same edge; latches clear.
- BVALID held until BVALID&BREADY; no new AW/W accepted while BVALID=1.
- BRESP: 2'b00 OKAY for mapped RW; 2'b10 SLVERR for ID or unmapped offsets (no state change).
- Read path: ARREADY = ~RVALID. On AR handshake, RDATA/RRESP registered, RVALID=1 next edge (1-cycle latency). Held stable until RREADY. Unmapped -> RDATA 0, RRESP 2'b10.
- Simultaneous read and write to same register: read returns pre-write value; channels fully independent.
- Blink: counter increments every cycle when BLINK_EN=1 and BLINK_PERIOD!=0; when counter==BLINK_PERIOD-1, counter->0 and phase toggles. BLINK_EN=0 or PERIOD=0: counter held 0, phase forced 1. Write to BLINK_PERIOD or CTRL resets counter to 0 (phase kept).
- Output stage (registered, 1 cycle after register/phase update): LEDG = (LEDG_REG & {9{phase}}) ^ {9{INVERT}}; LEDR likewise with 18 bits.
- Reset mid-transaction: all in-flight latches and pending responses dropped; master must not expect a response.

Decomposition:
- Shared package axi_lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, resp typedef; led_gpio register offset localparams and CTRL bit indices.
- One sub-module: led_blink_timer (counter + phase, inputs enable/period/restart, output phase).

Test Plan:
- Reset: hold ARESETN=0 10 cycles -> LEDG=0, LEDR=0, all VALIDs 0; read 0x0C -> 25_000_000, 0x10 -> 32'h4C454401, RRESP 00.
- Write 0x00 = 32'h1FF, AW 2 cycles before W -> BVALID once, BRESP 00; LEDG=9'h1FF two edges after commit.
- Write 0x04 = 32'hFFFF_FFFF, WSTRB=4'b0001 -> LEDR=18'h000FF; BREADY held low 5 cycles -> BVALID stays 1, AWREADY stays 0.
- Write 0x10 and read 0x18 -> BRESP 10, RRESP 10, RDATA 0, ID unchanged.
- PERIOD=4, CTRL=1, LEDG_REG=9'h0AA -> LEDG alternates 0AA/000 every 4 cycles; CTRL=3 -> alternates 155/1FF.
- Assert ARESETN low while AW latched, W pending -> no BVALID after release, LED registers 0, next write completes normally.
